johnson_decoder_monitor: RTL and testbench

//  Receive-side companion to the Johnson up/down counter. Samples a Johnson-coded

---
 rtl/johnson_pkg.sv | 33 +++
 rtl/johnson_step_classify.sv | 30 +++
 rtl/johnson_decoder_monitor.sv | 105 ++++++++++
 tb/tb_johnson_decoder_monitor.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson code helpers and lock-state type
package johnson_pkg;

  localparam int JMAX_W = 32;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // idx 0..W sets the low idx bits; idx W+j sets bits j..W-1 (the top W-j bits).
  function automatic logic [JMAX_W-1:0] johnson_encode(input int idx, input int width);
    logic [JMAX_W-1:0] c;
    c = '0;
    for (int b = 0; b < JMAX_W; b++) begin
      if (b < width) begin
        if (idx <= width) c[b] = (b < idx);
        else              c[b] = (b >= idx - width);
      end
    end
    return c;
  endfunction

  function automatic int johnson_decode(input logic [JMAX_W-1:0] code, input int width);
    int p;
    p = 0;
    for (int b = 0; b < JMAX_W; b++) begin
      if (b < width) p = p + int'(code[b]);
    end
    return code[width-1] ? (2 * width - p) : p;
  endfunction

endpackage

// File: rtl/johnson_step_classify.sv
// rtl/johnson_step_classify.sv - classifies the modular step between two Johnson indices
import johnson_pkg::*;

module johnson_step_classify #(
  parameter int WIDTH = 3,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] prev,
  output logic             hold,
  output logic             up,
  output logic             down,
  output logic             skip
);

  localparam logic [IDX_W:0] NS = (IDX_W + 1)'(2 * WIDTH);

  logic [IDX_W:0] d;

  always_comb begin
    if (idx >= prev) d = {1'b0, idx} - {1'b0, prev};
    else             d = {1'b0, idx} + NS - {1'b0, prev};
  end

  assign hold = (d == '0);
  assign up   = (d == (IDX_W + 1)'(1));
  assign down = (d == NS - (IDX_W + 1)'(1));
  assign skip = !(hold || up || down);

endmodule

// File: rtl/johnson_decoder_monitor.sv
// rtl/johnson_decoder_monitor.sv - Johnson code decoder with direction, lock and error tracking
import johnson_pkg::*;

module johnson_decoder_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code_in,
  output logic             out_valid,
  output logic [IDX_W-1:0] index,
  output logic             dir,
  output logic             hold,
  output logic             code_err,
  output logic             step_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  lock_state_t       state_q, state_d;
  logic [IDX_W-1:0]  index_d;
  logic              dir_d, hold_d, code_err_d, step_err_d, err_inc;
  logic [CNT_W-1:0]  err_count_d;

  logic [JMAX_W-1:0] code_ext, code_enc;
  logic [IDX_W-1:0]  dec_idx;
  logic              legal;
  logic              st_hold, st_up, st_down, st_skip;

  // Round-trip through the encoder: any word that does not re-encode to itself is illegal.
  assign code_ext = JMAX_W'(code_in);
  assign dec_idx  = IDX_W'(johnson_decode(code_ext, WIDTH));
  assign code_enc = johnson_encode(int'(dec_idx), WIDTH);
  assign legal    = (code_enc == code_ext);

  johnson_step_classify #(.WIDTH(WIDTH)) u_classify (
    .idx  (dec_idx),
    .prev (index),
    .hold (st_hold),
    .up   (st_up),
    .down (st_down),
    .skip (st_skip)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index;
    dir_d      = dir;
    hold_d     = 1'b0;
    code_err_d = 1'b0;
    step_err_d = 1'b0;
    err_inc    = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        code_err_d = 1'b1;
        err_inc    = 1'b1;
        state_d    = UNLOCKED;
      end else begin
        index_d = dec_idx;
        case (state_q)
          UNLOCKED: state_d = LOCKED;
          LOCKED: begin
            if (st_hold)      hold_d = 1'b1;
            else if (st_up)   dir_d  = 1'b0;
            else if (st_down) dir_d  = 1'b1;
            else if (st_skip) begin
              step_err_d = 1'b1;
              err_inc    = 1'b1;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
    err_count_d = (err_inc && (err_count != {CNT_W{1'b1}})) ? err_count + 1'b1 : err_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      out_valid <= 1'b0;
      index     <= '0;
      dir       <= 1'b0;
      hold      <= 1'b0;
      code_err  <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= in_valid;
      index     <= index_d;
      dir       <= dir_d;
      hold      <= hold_d;
      code_err  <= code_err_d;
      step_err  <= step_err_d;
      err_count <= err_count_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// tb/tb_johnson_decoder_monitor.sv - directed vector bench for johnson_decoder_monitor
module tb_johnson_decoder_monitor;

  typedef struct packed {
    logic       ov;
    logic [2:0] idx;
    logic       dir;
    logic       hold;
    logic       cerr;
    logic       serr;
    logic       lock;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] code;
    exp_t       e;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] code_in;
  logic       out_valid, dir, hold, code_err, step_err, locked;
  logic [2:0] index;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  johnson_decoder_monitor #(.WIDTH(3), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .out_valid (out_valid),
    .index     (index),
    .dir       (dir),
    .hold      (hold),
    .code_err  (code_err),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic v, input logic [2:0] code,
                              input logic ov, input logic [2:0] idx, input logic d,
                              input logic h, input logic ce, input logic se,
                              input logic lk, input logic [7:0] cnt);
    vec_t r;
    r.rst  = rst;
    r.v    = v;
    r.code = code;
    r.e    = '{ov: ov, idx: idx, dir: d, hold: h, cerr: ce, serr: se, lock: lk, cnt: cnt};
    return r;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{ov: out_valid, idx: index, dir: dir, hold: hold, cerr: code_err,
          serr: step_err, lock: locked, cnt: err_count};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got ov=%0b idx=%0d dir=%0b hold=%0b cerr=%0b serr=%0b lock=%0b cnt=%0d, want ov=%0b idx=%0d dir=%0b hold=%0b cerr=%0b serr=%0b lock=%0b cnt=%0d",
               name, a.ov, a.idx, a.dir, a.hold, a.cerr, a.serr, a.lock, a.cnt,
               e.ov, e.idx, e.dir, e.hold, e.cerr, e.serr, e.lock, e.cnt);
    end
  endtask

  task automatic apply(input logic rst, input logic v, input logic [2:0] code);
    reset    = rst;
    in_valid = v;
    code_in  = code;
    @(negedge clock);
  endtask

  vec_t vecs[$];
  exp_t zero_e;

  initial begin
    zero_e = '0;
    // T1: up count through the full cycle including 5->0 wrap
    vecs.push_back(mk(0,1,3'b000, 1,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b001, 1,1,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b011, 1,2,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b111, 1,3,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b110, 1,4,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b100, 1,5,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b000, 1,0,0,0,0,0,1,0));
    // T2: down from 0 wraps to 5
    vecs.push_back(mk(0,1,3'b100, 1,5,1,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b110, 1,4,1,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b111, 1,3,1,0,0,0,1,0));
    // T3: reach idx 1, illegal 010 unlocks, 111 relocks without step check
    vecs.push_back(mk(0,1,3'b011, 1,2,1,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b001, 1,1,1,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b010, 1,1,1,0,1,0,0,1));
    vecs.push_back(mk(0,1,3'b111, 1,3,1,0,0,0,1,1));
    // T4: reset (wins over in_valid), lock at 001, skip to 111, then down to 011
    vecs.push_back(mk(1,1,3'b001, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3'b001, 1,1,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,3'b111, 1,3,0,0,0,1,1,1));
    vecs.push_back(mk(0,1,3'b011, 1,2,1,0,0,0,1,1));
    // T5: hold, then idle gaps keep state
    vecs.push_back(mk(0,1,3'b011, 1,2,1,1,0,0,1,1));
    vecs.push_back(mk(0,0,3'b111, 0,2,1,0,0,0,1,1));
    vecs.push_back(mk(0,0,3'b101, 0,2,1,0,0,0,1,1));
    vecs.push_back(mk(0,1,3'b111, 1,3,0,0,0,0,1,1));
    vecs.push_back(mk(0,1,3'b101, 1,3,0,0,1,0,0,2));

    reset    = 1'b1;
    in_valid = 1'b0;
    code_in  = 3'b000;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_state", zero_e);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].v, vecs[i].code);
      check($sformatf("vec%0d", i), vecs[i].e);
    end

    // T6: drive the counter from 2 to 254 with illegal codes, then saturate
    for (int i = 0; i < 252; i++) apply(0, 1, 3'b010);
    check("cnt_254", '{ov:1, idx:3, dir:0, hold:0, cerr:1, serr:0, lock:0, cnt:8'd254});
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 3'b101);
      check($sformatf("sat%0d", i), '{ov:1, idx:3, dir:0, hold:0, cerr:1, serr:0, lock:0, cnt:8'd255});
    end
    apply(0, 1, 3'b000);
    check("relock_0", '{ov:1, idx:0, dir:0, hold:0, cerr:0, serr:0, lock:1, cnt:8'd255});
    apply(0, 1, 3'b100);
    check("down_5", '{ov:1, idx:5, dir:1, hold:0, cerr:0, serr:0, lock:1, cnt:8'd255});

    // Reset mid-stream, then a non-adjacent code only relocks
    apply(1, 1, 3'b010);
    check("midstream_reset", zero_e);
    apply(0, 1, 3'b111);
    check("post_reset_relock", '{ov:1, idx:3, dir:0, hold:0, cerr:0, serr:0, lock:1, cnt:8'd0});
    apply(0, 1, 3'b000);
    check("post_reset_skip", '{ov:1, idx:0, dir:0, hold:0, cerr:0, serr:1, lock:1, cnt:8'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
